fu_cdb_arbiter: RTL
===================

FU_CDB_ARBITER -- requirements
Module: fu_cdb_arbiter

Interface
REQ-001 Parameter `N: default 2; number of CDB broadcast slots per cycle.
REQ-002 Parameter `NUM_FU_ALU: default 3; ALU sources.
REQ-003 Parameter `NUM_FU_MULT: default 2; MULT sources.
REQ-004 Parameter `NUM_FU_LOAD: default 2; LOAD sources; S = ALU+MULT+LOAD total sources.
REQ-005 clock  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 squash  input  1  pipeline flush; synchronous.
REQ-008 fu_state_packet  input  FU_STATE_PACKET  prepared flags and result packets (alu, mult, load) from the FU block.
REQ-009 alu_avail  output  NUM_FU_ALU  per-ALU consume/free indication, combinational.
REQ-010 mult_avail  output  NUM_FU_MULT  per-MULT consume/free indication, combinational.
REQ-011 load_avail  output  NUM_FU_LOAD  per-LOAD consume/free indication, combinational.
REQ-012 cdb_packet  output  CDB_PACKET[N]  registered broadcast {valid, dest_prn, robn, result}.

Function
REQ-013 Global source index order SHALL be ALU[0..A-1], then MULT[0..M-1], then LOAD[0..L-1].
REQ-014 A source is a requester when its prepared bit is 1.
REQ-015 Grant: scan indices starting at rr_ptr, wrapping mod S; grant the first min(N, #requesters) requesters found; purely combinational in the same cycle.
REQ-016 avail[i] SHALL equal (!prepared[i]) || granted[i]; a prepared, ungranted source sees avail=0 and must hold its packet unchanged.
REQ-017 Granted packets SHALL be written into cdb_packet slots 0..g-1 in scan order on the next rising edge (latency 1); slots g..N-1 get valid=0.
REQ-018 cdb_packet.result/dest_prn/robn SHALL come from the source's basic fields (alu_packet[i].basic for ALU).
REQ-019 rr_ptr update: if g>0, rr_ptr <= (last granted index + 1) mod S; if g=0, rr_ptr holds.
REQ-020 Wrap-around: a scan crossing index S-1 continues at 0; rr_ptr never equals S.
REQ-021 Requesters <= N: all granted, all avail=1, no source starved.
REQ-022 Any requester waits at most ceil(S/N) cycles for a grant (round-robin fairness).
REQ-023 squash=1: all grants forced 0, all avail forced 1, next cycle cdb_packet all valid=0, rr_ptr <= 0; squash overrides requests in the same cycle.
REQ-024 Squash and reset asserted together: reset wins.

Reset
REQ-025 On reset assertion, immediately: cdb_packet[*].valid=0, dest_prn=0, robn=0, result=0; rr_ptr=0.
REQ-026 During reset, avail outputs SHALL be all 1 and no grants issued.
REQ-027 Reset mid-operation discards any registered broadcast; no partial packet emitted after deassertion.

Structure
REQ-028 CDB_PACKET typedef and `N, `NUM_FU_ALU, `NUM_FU_MULT, `NUM_FU_LOAD SHALL live in sys_defs.svh; FU_STATE_PACKET reused unchanged.
REQ-029 One sub-module rr_select: combinational N-of-S rotating selector (inputs req[S], ptr; outputs gnt[S], slot index per grant, last index, count).
REQ-030 Sequential state limited to cdb_packet registers and rr_ptr.

Verification (N=2, A=3, M=2, L=2, S=7)
REQ-031 Reset asserted mid-cycle with valid CDB -> cdb_packet valid=0 immediately, rr_ptr=0, all avail=1.
REQ-032 rr_ptr=0, only ALU1 prepared (robn=5, prn=12, result=0x1234) -> alu_avail=3'b111, next cycle slot0={1,12,5,0x1234}, slot1 valid=0, rr_ptr=2.
REQ-033 rr_ptr=0, all 7 prepared and held -> grants {0,1},{2,3},{4,5},{6,0} on successive cycles; avail low exactly for ungranted sources.
REQ-034 rr_ptr=5, requesters LOAD1(idx6) and ALU0(idx0) -> both granted, slot0=LOAD1, slot1=ALU0, rr_ptr=1.
REQ-035 MULT0 prepared, held 3 cycles under contention -> packet unchanged while mult_avail[0]=0, broadcast exactly once after grant.
REQ-036 squash with 4 requesters -> all avail=1, next cycle all valid=0, rr_ptr=0.

Source files
------------

// File: rtl/fu_cdb_arbiter_pkg.sv
// Shared types and default sizes for the CDB arbiter: functional-unit
// result packets, the FU state bundle and the registered CDB broadcast.
package fu_cdb_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int PRN_W = 6;
  localparam int ROB_W = 5;

  // Default machine shape; the arbiter parameters default to these and the
  // packet types below are sized by them.
  localparam int CDB_SLOTS     = 2;
  localparam int FU_ALU_COUNT  = 3;
  localparam int FU_MULT_COUNT = 2;
  localparam int FU_LOAD_COUNT = 2;
  localparam int FU_TOTAL      = FU_ALU_COUNT + FU_MULT_COUNT + FU_LOAD_COUNT;

  // Common result fields every functional unit carries.
  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [PRN_W-1:0] dest_prn;
    logic [ROB_W-1:0] robn;
  } FU_BASIC_PACKET;

  typedef struct packed {
    FU_BASIC_PACKET basic;
  } FU_PACKET;

  // Prepared flags plus the held result packets from every FU.
  typedef struct packed {
    logic [FU_ALU_COUNT-1:0]       alu_prepared;
    logic [FU_MULT_COUNT-1:0]      mult_prepared;
    logic [FU_LOAD_COUNT-1:0]      load_prepared;
    FU_PACKET [FU_ALU_COUNT-1:0]   alu_packet;
    FU_PACKET [FU_MULT_COUNT-1:0]  mult_packet;
    FU_PACKET [FU_LOAD_COUNT-1:0]  load_packet;
  } FU_STATE_PACKET;

  // One CDB broadcast slot.
  typedef struct packed {
    logic             valid;
    logic [PRN_W-1:0] dest_prn;
    logic [ROB_W-1:0] robn;
    logic [XLEN-1:0]  result;
  } CDB_PACKET;

  // Builds a valid broadcast from a source's basic fields.
  function automatic CDB_PACKET cdb_from_basic(input FU_BASIC_PACKET b);
    CDB_PACKET p;
    p.valid    = 1'b1;
    p.dest_prn = b.dest_prn;
    p.robn     = b.robn;
    p.result   = b.result;
    return p;
  endfunction

endpackage

// File: rtl/fu_cdb_arbiter_rr_select.sv
// Combinational N-of-S rotating selector: scans from ptr, wrapping mod S,
// and grants the first (up to) N requesters it meets, in scan order.
module fu_cdb_arbiter_rr_select #(
  parameter int S     = 7,
  parameter int N     = 2,
  parameter int IDX_W = $clog2(S),
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic [S-1:0]            req,
  input  logic [IDX_W-1:0]        ptr,
  output logic [S-1:0]            gnt,
  output logic [N-1:0][IDX_W-1:0] slot_idx,
  output logic [IDX_W-1:0]        last_idx,
  output logic [CNT_W-1:0]        count
);

  int idx;

  // Rotating scan: slot k of the broadcast gets the k-th requester found.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default first, so no path leaves a value unassigned and no latch forms.
    gnt      = '0;
    slot_idx = '0;
    last_idx = '0;
    count    = '0;
    idx      = 0;
    for (int k = 0; k < S; k++) begin
      idx = int'(ptr) + k;
      if (idx >= S) idx = idx - S;
      if (req[idx] && (int'(count) < N)) begin
        gnt[idx]        = 1'b1;
        slot_idx[count] = IDX_W'(idx);
        last_idx        = IDX_W'(idx);
        count           = count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fu_cdb_arbiter.sv
// Arbitrates functional-unit results onto an N-slot common data bus.
// Grants and avail are combinational; broadcasts appear one cycle later.
module fu_cdb_arbiter
  import fu_cdb_arbiter_pkg::*;
#(
  parameter int N           = CDB_SLOTS,
  parameter int NUM_FU_ALU  = FU_ALU_COUNT,
  parameter int NUM_FU_MULT = FU_MULT_COUNT,
  parameter int NUM_FU_LOAD = FU_LOAD_COUNT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   squash,
  input  FU_STATE_PACKET         fu_state_packet,
  output logic [NUM_FU_ALU-1:0]  alu_avail,
  output logic [NUM_FU_MULT-1:0] mult_avail,
  output logic [NUM_FU_LOAD-1:0] load_avail,
  output CDB_PACKET [N-1:0]      cdb_packet
);

  localparam int S     = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD;
  localparam int IDX_W = $clog2(S);
  localparam int CNT_W = $clog2(N + 1);

  logic [S-1:0]            prepared;
  logic [S-1:0]            req;
  logic [S-1:0]            gnt;
  logic [S-1:0]            avail;
  logic                    kill;
  logic [N-1:0][IDX_W-1:0] slot_idx;
  logic [IDX_W-1:0]        last_idx;
  logic [CNT_W-1:0]        count;
  logic [IDX_W-1:0]        rr_ptr;
  FU_BASIC_PACKET          src_basic [S];
  CDB_PACKET [N-1:0]       cdb_next;

  // Global source order is ALU, then MULT, then LOAD.
  assign prepared = {fu_state_packet.load_prepared,
                     fu_state_packet.mult_prepared,
                     fu_state_packet.alu_prepared};

  // Reset or squash suppress every grant and free every source.
  assign kill = reset | squash;
  assign req  = kill ? '0 : prepared;

  fu_cdb_arbiter_rr_select #(
    .S     (S),
    .N     (N),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_rr_select (
    .req      (req),
    .ptr      (rr_ptr),
    .gnt      (gnt),
    .slot_idx (slot_idx),
    .last_idx (last_idx),
    .count    (count)
  );

  // A prepared source that lost arbitration must hold its packet.
  assign avail      = kill ? '1 : (~prepared | gnt);
  assign alu_avail  = avail[NUM_FU_ALU-1:0];
  assign mult_avail = avail[NUM_FU_ALU +: NUM_FU_MULT];
  assign load_avail = avail[NUM_FU_ALU+NUM_FU_MULT +: NUM_FU_LOAD];

  // Flatten the per-FU packets into global source order.
  always_comb begin
    src_basic = '{default: '0};
    for (int i = 0; i < NUM_FU_ALU; i++)
      src_basic[i] = fu_state_packet.alu_packet[i].basic;
    for (int i = 0; i < NUM_FU_MULT; i++)
      src_basic[NUM_FU_ALU+i] = fu_state_packet.mult_packet[i].basic;
    for (int i = 0; i < NUM_FU_LOAD; i++)
      src_basic[NUM_FU_ALU+NUM_FU_MULT+i] = fu_state_packet.load_packet[i].basic;
  end

  // Pack granted sources into slots 0..count-1; unused slots stay empty.
  always_comb begin
    cdb_next = '0;
    for (int s = 0; s < N; s++) begin
      if (s < int'(count))
        cdb_next[s] = cdb_from_basic(src_basic[slot_idx[s]]);
    end
  end

  // Broadcast register: a squash empties the bus on the next edge.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    if (reset)       cdb_packet <= '0;
    else if (squash) cdb_packet <= '0;
    else             cdb_packet <= cdb_next;
  end

  // Round-robin pointer: resume just past the last granted source.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            rr_ptr <= '0;
    else if (squash)      rr_ptr <= '0;
    else if (count != '0) rr_ptr <= (int'(last_idx) == S - 1) ? '0 : last_idx + 1'b1;
  end

endmodule
